// File: rtl/ad7606_line_packer.sv
// Serialises 8-channel AD7606 sample sets into a CSI byte stream. Each line is a
// 16-byte header followed by SETS_PER_LINE sets, and the stream stalls on FIFO full.
module ad7606_line_packer #(
  parameter int          SETS_PER_LINE = 63,
  parameter logic [15:0] SYNC_WORD     = 16'hEB90
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_valid,
  input  logic [127:0] sample_data,
  input  logic         fifo_full,
  output logic         fifo_wr_en,
  output logic [7:0]   fifo_wr_data,
  output logic         line_start,
  output logic         drop_pulse
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic          hold_full;
  logic [127:0]  hold_data, shift_data;
  logic [15:0]   seq, drop_cnt, hdr_drop, set_cnt;
  logic          out_valid, out_first;
  logic [7:0]    out_byte;

  logic          adv, have, take_hold, snap, set_done, first;
  logic [7:0]    byte_nxt;
  logic          capture, drop;

  function automatic logic [7:0] header_byte(input logic [3:0] i, input logic [15:0] s,
                                             input logic [15:0] d);
    case (i)
      4'd0:    header_byte = SYNC_WORD[15:8];
      4'd1:    header_byte = SYNC_WORD[7:0];
      4'd2:    header_byte = s[15:8];
      4'd3:    header_byte = s[7:0];
      4'd4:    header_byte = d[15:8];
      4'd5:    header_byte = d[7:0];
      default: header_byte = 8'h00;
    endcase
  endfunction

  // Even byte index is the high byte of channel idx/2, odd is the low byte.
  function automatic logic [7:0] payload_byte(input logic [127:0] d, input logic [3:0] i);
    logic [6:0] base;
    base = {i[3:1], 4'b0000} + (i[0] ? 7'd0 : 7'd8);
    payload_byte = d[base +: 8];
  endfunction

  // The output register may take a new byte when empty or when its byte is written.
  assign adv          = ~out_valid | ~fifo_full;
  assign fifo_wr_en   = out_valid & ~fifo_full;
  assign fifo_wr_data = out_byte;
  assign line_start   = fifo_wr_en & out_first;

  assign capture = sample_valid & (~hold_full | (adv & take_hold));
  assign drop    = sample_valid & ~capture;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    have      = 1'b0;
    byte_nxt  = 8'h00;
    take_hold = 1'b0;
    snap      = 1'b0;
    set_done  = 1'b0;
    first     = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          have    = 1'b1;
          idx_nxt = 4'd1;
          if (set_cnt == 16'd0) begin
            byte_nxt  = SYNC_WORD[15:8];
            first     = 1'b1;
            snap      = 1'b1;
            state_nxt = HEADER;
          end else begin
            byte_nxt  = hold_data[15:8];
            take_hold = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end
      HEADER: begin
        have     = 1'b1;
        byte_nxt = header_byte(idx, seq, hdr_drop);
        idx_nxt  = idx + 4'd1;
        if (idx == 4'd15) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        have    = 1'b1;
        idx_nxt = idx + 4'd1;
        if (idx == 4'd0) begin
          byte_nxt  = hold_data[15:8];
          take_hold = 1'b1;
        end else begin
          byte_nxt = payload_byte(shift_data, idx);
        end
        if (idx == 4'd15) begin
          set_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 4'd0;
      hold_full  <= 1'b0;
      seq        <= 16'd0;
      drop_cnt   <= 16'd0;
      set_cnt    <= 16'd0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_byte   <= 8'h00;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (capture)              hold_full <= 1'b1;
      else if (adv && take_hold) hold_full <= 1'b0;

      if (adv && snap)                          drop_cnt <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_cnt != 16'hFFFF)    drop_cnt <= drop_cnt + 16'd1;

      if (adv) begin
        state     <= state_nxt;
        idx       <= idx_nxt;
        out_valid <= have;
        out_first <= first;
        if (have) out_byte <= byte_nxt;
        if (set_done) begin
          if (set_cnt == 16'(SETS_PER_LINE - 1)) begin
            set_cnt <= 16'd0;
            seq     <= seq + 16'd1;
          end else begin
            set_cnt <= set_cnt + 16'd1;
          end
        end
      end
    end
  end

  // Sample datapath
  always_ff @(posedge clk) begin
    if (capture)         hold_data  <= sample_data;
    if (adv && take_hold) shift_data <= hold_data;
    if (adv && snap)      hdr_drop   <= drop_cnt;
  end

endmodule

// File: tb/tb_ad7606_line_packer.sv
// Directed bench for ad7606_line_packer: captures every FIFO write and compares the
// stream against hand-built header/sample byte sequences.
module tb_ad7606_line_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_valid = 1'b0;
  logic [127:0] sample_data = '0;
  logic         fifo_full = 1'b0;
  logic         fifo_wr_en;
  logic [7:0]   fifo_wr_data;
  logic         line_start;
  logic         drop_pulse;

  ad7606_line_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .line_start   (line_start),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int drops = 0;
  int ls_total = 0;
  int full_viol = 0;
  logic [7:0] got_q[$];
  logic       ls_q[$];
  int         cyc_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      got_q.push_back(fifo_wr_data);
      ls_q.push_back(line_start);
      cyc_q.push_back(cycle);
    end
    if (line_start) ls_total++;
    if (drop_pulse) drops++;
    if (fifo_wr_en && fifo_full) full_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete(); ls_q.delete(); cyc_q.delete(); exp_q.delete();
    drops = 0; ls_total = 0; full_viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sample_valid = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
  endtask

  function automatic logic [127:0] make_set(input logic [7:0] k);
    logic [127:0] r;
    for (int n = 0; n < 8; n++) r[16*n +: 16] = {k, 8'(n)};
    return r;
  endfunction

  task automatic pulse(input logic [7:0] k);
    @(posedge clk);
    #1 sample_valid = 1'b1; sample_data = make_set(k);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic exp_header(input logic [15:0] s, input logic [15:0] d);
    exp_q.push_back(8'hEB); exp_q.push_back(8'h90);
    exp_q.push_back(s[15:8]); exp_q.push_back(s[7:0]);
    exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h00);
  endtask

  task automatic exp_set(input logic [7:0] k);
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(k);
      exp_q.push_back(8'(n));
    end
  endtask

  task automatic wait_for(input int n, input int budget, input string tag);
    int i = 0;
    while (got_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check({tag, "_reached"}, 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    int nb = 0;
    int first_bad = -1;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        nb++;
      end
    end
    if (first_bad >= 0)
      check($sformatf("%s_byte%0d", tag, first_bad), 32'(got_q[first_bad]), 32'(exp_q[first_bad]));
    check({tag, "_badbytes"}, 32'(nb), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    check("rst_line_start", 32'(line_start), 32'd0);
    check("rst_drop_pulse", 32'(drop_pulse), 32'd0);

    // Single set: latency, header, payload ordering
    pulse(8'h11);
    @(negedge clk);
    check("lat_t1_wr_en", 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    check("lat_t2_wr_en", 32'(fifo_wr_en), 32'd1);
    check("lat_t2_data", 32'(fifo_wr_data), 32'hEB);
    check("lat_t2_line_start", 32'(line_start), 32'd1);
    wait_for(32, 100, "single");
    repeat (20) @(posedge clk);
    exp_header(16'h0000, 16'h0000);
    exp_set(8'h11);
    cmp_stream("single");
    check("single_span", 32'(cyc_q[31] - cyc_q[0]), 32'd31);
    check("single_ls_total", 32'(ls_total), 32'd1);

    // Full line of 63 sets plus the first set of the next line
    do_reset();
    for (int k = 0; k < 64; k++) begin
      pulse(8'(k));
      repeat (38) @(posedge clk);
    end
    wait_for(1040, 2000, "line");
    repeat (20) @(posedge clk);
    exp_header(16'h0000, 16'h0000);
    for (int k = 0; k < 63; k++) exp_set(8'(k));
    exp_header(16'h0001, 16'h0000);
    exp_set(8'd63);
    cmp_stream("line");
    check("line_ls0", 32'(ls_q[0]), 32'd1);
    check("line_ls1024", 32'(ls_q[1024]), 32'd1);
    check("line_ls_total", 32'(ls_total), 32'd2);
    check("line_drops", 32'(drops), 32'd0);

    // Backpressure for 5 cycles mid-payload
    do_reset();
    pulse(8'h3C);
    wait_for(20, 100, "bp");
    #1 fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_for(32, 100, "bp_done");
    repeat (20) @(posedge clk);
    exp_header(16'h0000, 16'h0000);
    exp_set(8'h3C);
    cmp_stream("bp");
    check("bp_span", 32'(cyc_q[31] - cyc_q[0]), 32'd36);
    check("bp_full_viol", 32'(full_viol), 32'd0);

    // Drops under full, drop field in next header, seq wrap FFFF -> 0000
    do_reset();
    fifo_full = 1'b1;
    pulse(8'h20);
    repeat (18) @(posedge clk);
    pulse(8'h21);
    repeat (18) @(posedge clk);
    pulse(8'h22);
    repeat (5) @(posedge clk);
    check("drop_during_full_wr", 32'(got_q.size()), 32'd0);
    #1 fifo_full = 1'b0;
    check("drop_pulses", 32'(drops), 32'd2);
    wait_for(32, 100, "drop_first");
    force dut.seq = 16'hFFFF;
    @(posedge clk);
    #1 release dut.seq;
    for (int k = 1; k < 63; k++) begin
      pulse(8'(k + 8'h40));
      repeat (38) @(posedge clk);
    end
    pulse(8'hF0);
    wait_for(1040, 2000, "drop_line");
    repeat (20) @(posedge clk);
    exp_header(16'h0000, 16'h0000);
    exp_set(8'h20);
    for (int k = 1; k < 63; k++) exp_set(8'(k + 8'h40));
    exp_header(16'h0000, 16'h0002);
    exp_set(8'hF0);
    cmp_stream("drop_line");
    check("drop_line_ls_total", 32'(ls_total), 32'd2);
    check("drop_total", 32'(drops), 32'd2);

    // Asynchronous reset during payload byte 7
    do_reset();
    pulse(8'h55);
    wait_for(23, 100, "arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("arst_wr_data", 32'(fifo_wr_data), 32'd0);
    check("arst_line_start", 32'(line_start), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
    pulse(8'h66);
    wait_for(32, 100, "arst_after");
    repeat (20) @(posedge clk);
    exp_header(16'h0000, 16'h0000);
    exp_set(8'h66);
    cmp_stream("arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
